// File: rtl/alu_rr_sequencer_if.sv
// Bundle of request, ALU-drive and response signals between the requesters/ALU
// and the round-robin sequencer.
interface alu_rr_sequencer_if #(
    parameter int WIDTH   = 128,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [4*NUM_REQ-1:0]     req_opcode;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;

    logic [3:0]               alu_opcode;
    logic [WIDTH-1:0]         alu_in1;
    logic [WIDTH-1:0]         alu_in2;
    logic [WIDTH-1:0]         alu_result;
    logic                     alu_carry;
    logic                     alu_zero;
    logic                     alu_sign;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_result;
    logic [2:0]               resp_flags;
    logic                     resp_err;
    logic                     busy;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b,
        input  alu_result, alu_carry, alu_zero, alu_sign,
        input  resp_ready,
        output req_ready, alu_opcode, alu_in1, alu_in2,
        output resp_valid, resp_id, resp_result, resp_flags, resp_err, busy
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b,
        output alu_result, alu_carry, alu_zero, alu_sign,
        output resp_ready,
        input  req_ready, alu_opcode, alu_in1, alu_in2,
        input  resp_valid, resp_id, resp_result, resp_flags, resp_err, busy
    );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Round-robin sharing of one external combinational ALU among NUM_REQ requesters,
// one operation in flight, opcode-dependent hold time, tagged valid/ready response.
module alu_rr_sequencer #(
    parameter int WIDTH      = 128,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_rr_sequencer_if.slave bus
);
    localparam logic [3:0]      OP_MUL    = 4'd5;
    localparam logic [3:0]      OP_LAST   = 4'd10;
    localparam int              CNT_W     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_CYCLES - 1);
    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
    logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
    logic             resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic [2:0]       resp_flags_q, resp_flags_d;
    logic             resp_err_q, resp_err_d;
    logic             busy_q, busy_d;

    logic [3:0]       opc_arr [NUM_REQ];
    logic [WIDTH-1:0] a_arr   [NUM_REQ];
    logic [WIDTH-1:0] b_arr   [NUM_REQ];
    logic [ID_W-1:0]  rot_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_valid;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;

    // Slot gi of the rotated view is requester (rr_ptr + gi) mod NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [ID_W:0] rot_sum;
            assign rot_sum       = {1'b0, rr_ptr_q} + (ID_W+1)'(gi);
            assign rot_idx[gi]   = (rot_sum >= NUM_REQ_X) ? ID_W'(rot_sum - NUM_REQ_X)
                                                          : rot_sum[ID_W-1:0];
            assign rot_valid[gi] = bus.req_valid[rot_idx[gi]];
            assign opc_arr[gi]   = bus.req_opcode[4*gi +: 4];
            assign a_arr[gi]     = bus.req_a[WIDTH*gi +: WIDTH];
            assign b_arr[gi]     = bus.req_b[WIDTH*gi +: WIDTH];
        end
    endgenerate

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        if (state_q == S_IDLE && !rst) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (rot_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_id  = rot_idx[k];
                end
            end
        end
    end

    assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        alu_opcode_d  = alu_opcode_q;
        alu_in1_d     = alu_in1_q;
        alu_in2_d     = alu_in2_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        resp_err_d    = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    id_d         = grant_id;
                    alu_opcode_d = opc_arr[grant_id];
                    alu_in1_d    = a_arr[grant_id];
                    alu_in2_d    = b_arr[grant_id];
                    // Undefined opcodes never touch the ALU and answer straight away.
                    if (opc_arr[grant_id] > OP_LAST) begin
                        state_d       = S_RESP;
                        resp_err_d    = 1'b1;
                        resp_result_d = '0;
                        resp_flags_d  = '0;
                        resp_id_d     = grant_id;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = (opc_arr[grant_id] == OP_MUL) ? MUL_CNT : '0;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    resp_result_d = bus.alu_result;
                    resp_flags_d  = {bus.alu_carry, bus.alu_zero, bus.alu_sign};
                    resp_err_d    = 1'b0;
                    resp_id_d     = id_q;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        resp_valid_d = (state_d == S_RESP);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            cnt_q         <= '0;
            alu_opcode_q  <= '0;
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            resp_err_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            cnt_q         <= cnt_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_in1_q     <= alu_in1_d;
            alu_in2_q     <= alu_in2_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
            resp_err_q    <= resp_err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.alu_opcode  = alu_opcode_q;
    assign bus.alu_in1     = alu_in1_q;
    assign bus.alu_in2     = alu_in2_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_flags  = resp_flags_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: behavioural ALU, transaction-level model checked every
// cycle, and directed scenarios with hand-computed expectations.
module tb_alu_rr_sequencer;
    localparam int WIDTH      = 128;
    localparam int NUM_REQ    = 4;
    localparam int ID_W       = 2;
    localparam int MUL_CYCLES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_rr_sequencer_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

    alu_rr_sequencer #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_CYCLES(MUL_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pcyc  = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    // Returns {carry, zero, sign, result}.
    function automatic logic [WIDTH+2:0] alu_f(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             c;
        wide = '0;
        r    = '0;
        c    = 1'b0;
        case (op)
            4'd0:  begin wide = {1'b0, a} + {1'b0, b}; r = wide[WIDTH-1:0]; c = wide[WIDTH]; end
            4'd1:  begin wide = {1'b0, a} - {1'b0, b}; r = wide[WIDTH-1:0]; c = wide[WIDTH]; end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = WIDTH'($signed(a) > $signed(b));
            4'd5:  r = a * b;
            4'd6:  r = WIDTH'(a == b);
            4'd7:  r = WIDTH'(a != b);
            4'd8:  r = WIDTH'($signed(a) < $signed(b));
            4'd9:  r = WIDTH'($signed(a) >= $signed(b));
            4'd10: r = a ^ b;
            default: r = '0;
        endcase
        return {c, (r == '0), r[WIDTH-1], r};
    endfunction

    logic [WIDTH+2:0] alu_o;
    assign alu_o          = alu_f(bus.alu_opcode, bus.alu_in1, bus.alu_in2);
    assign bus.alu_result = alu_o[WIDTH-1:0];
    assign bus.alu_sign   = alu_o[WIDTH];
    assign bus.alu_zero   = alu_o[WIDTH+1];
    assign bus.alu_carry  = alu_o[WIDTH+2];

    task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, pcyc);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    // Transaction-level model: one job at a time, fixed latency per opcode class,
    // round-robin pointer moves past the requester whose response completed.
    bit               m_busy = 1'b0;
    int               m_ptr  = 0;
    int               m_id, m_acc, m_lat;
    logic [3:0]       m_op;
    logic [WIDTH-1:0] m_a, m_b, m_res;
    logic [2:0]       m_flags;
    logic             m_err;

    initial forever begin
        int                 pick;
        logic [NUM_REQ-1:0] exp_ready;
        bit                 exp_v;
        logic [WIDTH+2:0]   o;
        @(negedge clk);
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_resp_valid", bus.resp_valid, 0);
            check("rst_busy", bus.busy, 0);
        end else begin
            pick      = rr_pick(bus.req_valid, m_ptr);
            exp_ready = '0;
            if (!m_busy && pick >= 0) exp_ready[pick] = 1'b1;
            exp_v = m_busy && ((pcyc - m_acc) >= m_lat);
            check("req_ready", bus.req_ready, exp_ready);
            check("busy", bus.busy, m_busy);
            check("resp_valid", bus.resp_valid, exp_v);
            if (m_busy) begin
                check("alu_opcode", bus.alu_opcode, m_op);
                check("alu_in1", bus.alu_in1, m_a);
                check("alu_in2", bus.alu_in2, m_b);
            end
            if (exp_v) begin
                check("resp_id", bus.resp_id, m_id);
                check("resp_result", bus.resp_result, m_res);
                check("resp_flags", bus.resp_flags, m_flags);
                check("resp_err", bus.resp_err, m_err);
            end
            if (!m_busy && pick >= 0) begin
                m_busy = 1'b1;
                m_id   = pick;
                m_acc  = pcyc;
                m_op   = bus.req_opcode[4*pick +: 4];
                m_a    = bus.req_a[WIDTH*pick +: WIDTH];
                m_b    = bus.req_b[WIDTH*pick +: WIDTH];
                if (m_op > 4'd10) begin
                    m_lat = 1; m_res = '0; m_flags = '0; m_err = 1'b1;
                end else begin
                    o       = alu_f(m_op, m_a, m_b);
                    m_res   = o[WIDTH-1:0];
                    m_flags = o[WIDTH+2:WIDTH];
                    m_err   = 1'b0;
                    m_lat   = (m_op == 4'd5) ? 1 + MUL_CYCLES : 2;
                end
                $display("accept   cyc=%0d id=%0d op=%0d a=%h b=%h", pcyc, m_id, m_op, m_a, m_b);
            end else if (exp_v && bus.resp_ready) begin
                $display("response cyc=%0d id=%0d result=%h flags=%b err=%0d", pcyc, m_id, m_res, m_flags, m_err);
                m_busy = 1'b0;
                m_ptr  = (m_id + 1) % NUM_REQ;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.req_opcode[4*id +: 4]   = op;
        bus.req_a[WIDTH*id +: WIDTH] = a;
        bus.req_b[WIDTH*id +: WIDTH] = b;
        bus.req_valid[id]           = 1'b1;
    endtask

    task automatic wait_grant(output logic [NUM_REQ-1:0] g, output int acc);
        g   = '0;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                g   = bus.req_ready;
                acc = pcyc;
                break;
            end
        end
        if (acc < 0) check("grant_timeout", 0, 1);
    endtask

    task automatic wait_resp(input int acc, output int lat, output logic [WIDTH-1:0] res,
                             output logic [2:0] fl, output logic er, output logic [ID_W-1:0] rid);
        lat = -1; res = '0; fl = '0; er = 1'b0; rid = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = pcyc - acc;
                res = bus.resp_result;
                fl  = bus.resp_flags;
                er  = bus.resp_err;
                rid = bus.resp_id;
                break;
            end
        end
        if (lat < 0) check("resp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.resp_valid) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_timeout", done, 1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [NUM_REQ-1:0] g;
        int                 acc, lat;
        logic [WIDTH-1:0]   res, exp_fe;
        logic [2:0]         fl;
        logic               er;
        logic [ID_W-1:0]    rid;
        int                 glog[$];
        int                 exp_order[5] = '{0, 1, 2, 3, 0};

        bus.req_valid  = '1;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;

        // Reset: ready forced low even with every requester valid.
        @(negedge clk);
        check("t0_ready", bus.req_ready, 0);
        check("t0_alu_op", bus.alu_opcode, 0);
        check("t0_resp_result", bus.resp_result, 0);
        tick();
        bus.req_valid = '0;
        rst = 1'b0;

        // ADD all-ones + 1 from requester 1.
        set_req(1, 4'd0, '1, 1);
        wait_grant(g, acc);
        check("t1_ready", g, 4'b0010);
        tick();
        bus.req_valid[1] = 1'b0;
        check("t1_ready_drop", bus.req_ready, 0);
        wait_resp(acc, lat, res, fl, er, rid);
        check("t1_lat", lat, 2);
        check("t1_id", rid, 1);
        check("t1_result", res, 0);
        check("t1_flags", fl, 3'b110);
        check("t1_err", er, 0);
        wait_idle();

        // MUL 3*5 from requester 0.
        set_req(0, 4'd5, 3, 5);
        wait_grant(g, acc);
        check("t2_ready", g, 4'b0001);
        tick();
        bus.req_valid[0] = 1'b0;
        for (int i = 0; i < MUL_CYCLES; i++) begin
            @(negedge clk);
            check("t2_hold_op", bus.alu_opcode, 5);
            check("t2_no_resp", bus.resp_valid, 0);
        end
        wait_resp(acc, lat, res, fl, er, rid);
        check("t2_lat", lat, 5);
        check("t2_result", res, 15);
        check("t2_err", er, 0);
        wait_idle();

        // Reset during MUL execution from requester 3.
        set_req(3, 4'd5, 7, 9);
        wait_grant(g, acc);
        check("t3_ready", g, 4'b1000);
        tick();
        bus.req_valid[3] = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t3_rst_busy", bus.busy, 0);
        check("t3_rst_valid", bus.resp_valid, 0);
        check("t3_rst_alu_op", bus.alu_opcode, 0);
        check("t3_rst_alu_in1", bus.alu_in1, 0);
        check("t3_rst_alu_in2", bus.alu_in2, 0);
        check("t3_rst_ready", bus.req_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_no_resp", bus.resp_valid, 0);
        end
        tick();

        // All requesters continuously valid with XOR.
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 4'd10, WIDTH'(k * 3 + 1), WIDTH'(32'h55 << k));
        for (int i = 0; i < 300 && glog.size() < 5; i++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++)
                if (bus.req_ready[k]) glog.push_back(k);
        end
        tick();
        bus.req_valid = '0;
        check("t4_count", glog.size(), 5);
        for (int k = 0; k < glog.size() && k < 5; k++) check("t4_order", glog[k], exp_order[k]);
        wait_idle();

        // Undefined opcode from requester 2; 3 then 0 wait behind it.
        set_req(2, 4'hC, 123, 456);
        wait_grant(g, acc);
        check("t5_ready", g, 4'b0100);
        tick();
        bus.req_valid[2] = 1'b0;
        set_req(3, 4'd0, 10, 20);
        set_req(0, 4'd3, 128'hF0, 128'h0F);
        wait_resp(acc, lat, res, fl, er, rid);
        check("t5_lat", lat, 1);
        check("t5_err", er, 1);
        check("t5_result", res, 0);
        check("t5_flags", fl, 0);
        check("t5_id", rid, 2);
        tick();
        wait_grant(g, acc);
        check("t5_next", g, 4'b1000);
        tick();
        bus.req_valid[3] = 1'b0;
        wait_grant(g, acc);
        check("t5_after", g, 4'b0001);
        tick();
        bus.req_valid[0] = 1'b0;
        wait_idle();

        // SUB 5-7 with the response held off for 10 cycles.
        exp_fe    = '1;
        exp_fe[0] = 1'b0;
        bus.resp_ready = 1'b0;
        set_req(1, 4'd1, 5, 7);
        set_req(2, 4'd2, 128'hFF, 128'h3C);
        wait_grant(g, acc);
        check("t6_ready", g, 4'b0010);
        tick();
        bus.req_valid[1] = 1'b0;
        wait_resp(acc, lat, res, fl, er, rid);
        check("t6_lat", lat, 2);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("t6_hold_valid", bus.resp_valid, 1);
            check("t6_hold_result", bus.resp_result, exp_fe);
            check("t6_hold_flags", bus.resp_flags, 3'b101);
            check("t6_hold_ready", bus.req_ready, 0);
        end
        tick();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_idle_busy", bus.busy, 0);
        check("t6_idle_valid", bus.resp_valid, 0);
        check("t6_next_grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid[2] = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
